keypad_scan_fifo: RTL and testbench
===================================

# keypad_scan_fifo

Parametrised matrix-keypad controller for the I/O bus. It scans a ROWS×COLS key matrix and debounces both press and release. Each accepted key is encoded as a linear code and queued in a FIFO that the CPU drains through the same CS_N/IOR_N read strobe used by the other I/O blocks. It adds configurable matrix size, FIFO buffering, overflow reporting and an interrupt. The single-key, one-shot "valid" flag of the earlier design is dropped.

## Interface
- ROWS, 4: number of row inputs, 1..16.
- COLS, 4: number of column outputs, 1..16. ROWS*COLS ≤ 256.
- DEBOUNCE, 2000000: press/release stability window in wb_clk_i cycles (≥2).
- SCAN_DIV, 16: cycles each column is held low before rows are sampled (≥3).
- FIFO_DEPTH, 8: key FIFO entries, power of two, ≥2.
- KW: localparam, $clog2(ROWS*COLS) (min 1), key-code width.
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- CS_N  in  1  chip select, active low.
- IOR_N  in  1  read strobe, active low.
- IOW_N  in  1  write strobe, active low.
- addr  in  1  register select: 0 = DATA, 1 = STATUS/CTRL.
- wb_dat_i  in  16  write data.
- wb_dat_o  out  16  read data.
- row  in  ROWS  matrix rows, pulled up; low = key on the driven column.
- col  out  COLS  column drive; a driven column is low.
- irq_o  out  1  level interrupt.

## Operation
- row passes through a 2-FF synchronizer. All scan logic uses the synchronized value rs.
- Scan FSM states:
  - IDLE: col = all 0. If rs != all 1, clear the counter and go to DEB_PRESS.
  - DEB_PRESS: col = all 0. The counter increments while rs != all 1. If rs returns to all 1, go to IDLE. When the counter reaches DEBOUNCE-1, go to SCAN with column index c = 0.
  - SCAN: col = ~(1<<c). Hold for SCAN_DIV cycles, then sample rs.
    - If any row is low, the key is (r = lowest low row index, c); go to PUSH.
    - Otherwise c++. If c == COLS, set c = 0 and return to IDLE (spurious press).
  - PUSH: one cycle. code = c*ROWS + r (KW bits). Enqueue the code, then go to DEB_REL with col = all 0.
  - DEB_REL: the counter counts cycles with rs == all 1 and clears on any low row. At DEBOUNCE-1, go to IDLE.
- One code is produced per press. Held keys do not auto-repeat. A second key pressed while the first is held is ignored until all keys are released.
- FIFO:
  - Push occurs in PUSH.
  - Pop occurs on the first cycle of a DATA read access: CS_N=0, IOR_N=0, addr=0, with the access-active flag previously clear. Exactly one pop per access, regardless of strobe length. A pop when empty has no effect.
  - Push with the FIFO full and no pop in the same cycle: the code is dropped and sticky ovf is set.
  - Push and pop in the same cycle: both take effect (including when full), count unchanged.
- DATA read: wb_dat_o = {~empty, ovf, 14-KW zeros, head code}. When empty the code field is 0.
- STATUS read: wb_dat_o = {ovf, full, empty, ie, 7'b0, count[4:0]} (count saturates at 31 for display).
- CTRL write: triggered on the first cycle of CS_N=0, IOW_N=0, addr=1.
  - wb_dat_i[0]=1 clears ovf.
  - wb_dat_i[1] is written to ie.
- irq_o = ie & (~empty | ovf).
- wb_dat_o = 0 whenever CS_N or IOR_N is high. It is combinational from addr and state.

## Timing
- Reset values: col = all 0, FSM = IDLE, FIFO empty, count = 0, ovf = 0, ie = 0, irq_o = 0, wb_dat_o = 0, synchronizer flops = all 1.
- Reset asserted mid-scan or mid-debounce aborts immediately. Queued codes are discarded.
- Press-to-enqueue latency, for a clean press on column c:
  - 2 (sync) + DEBOUNCE (DEB_PRESS) + (c+1)*SCAN_DIV + 1 (PUSH) cycles after the row first goes low at the pin.
  - The code is visible at DATA on the cycle after PUSH.
- Pop takes effect at the clock edge ending the first access cycle. The next head is visible at the start of the next access.
- ovf sets on the edge ending the dropped PUSH cycle. A simultaneous clear and set leaves ovf = 1.
- The FIFO pointers wrap modulo FIFO_DEPTH. full = (count == FIFO_DEPTH).

## Test plan
Bench configuration: ROWS=COLS=4, DEBOUNCE=20, SCAN_DIV=4, FIFO_DEPTH=4.
- Reset: assert wb_rst_i mid-SCAN → col=4'b0000, irq_o=0, STATUS read = 16'h2000.
- Single key: short row[2]↔col[1] clean for 100 cycles, then release → one DATA read returns 16'h8006; the next read returns 16'h0000.
- Bounce: toggle row[0] low/high every 5 cycles for 60 cycles, then hold low on col 3 → exactly one code 12 is queued. A release with bounce yields no extra code.
- FIFO full/overflow: 5 presses (codes 0,5,10,15,1) with no reads → STATUS = 16'hC004 (ovf, full, count 4). Reads return 0,5,10,15 with bit14 set. CTRL write 16'h0001 clears ovf.
- Long strobe and simultaneous push/pop: hold IOR_N low 10 cycles → one pop only. A pop coinciding with PUSH while full → count stays 4, ovf stays 0.
- Interrupt: write CTRL 16'h0002, press key 9 → irq_o=1 after enqueue. Reading DATA (16'h8009) → irq_o=0 on the next cycle.

Source files
------------

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad controller: scans ROWS x COLS keys, debounces press and release,
// and queues linear key codes in a FIFO drained through the CS_N/IOR_N read strobe.
module keypad_scan_fifo #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DEBOUNCE   = 2000000,
  parameter int SCAN_DIV   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            CS_N,
  input  logic            IOR_N,
  input  logic            IOW_N,
  input  logic            addr,
  input  logic [15:0]     wb_dat_i,
  output logic [15:0]     wb_dat_o,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic            irq_o
);

  localparam int NK = ROWS * COLS;
  localparam int KW = (NK > 1) ? $clog2(NK) : 1;
  localparam int DW = $clog2(DEBOUNCE);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DEB_PRESS, S_SCAN, S_PUSH, S_DEB_REL
  } state_t;

  state_t          state_q, state_d;
  logic [ROWS-1:0] rs1_q, rs_q;
  logic [DW-1:0]   deb_q, deb_d;
  logic [SW-1:0]   div_q, div_d;
  logic [CW-1:0]   c_q, c_d;
  logic [RW-1:0]   r_q, r_d;
  logic [RW-1:0]   low_idx;
  logic            any_low;
  logic            push;
  logic [KW-1:0]   code;

  logic [KW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d, ie_q, ie_d;
  logic            rd_act_q, wr_act_q;
  logic            rd_acc, wr_acc, pop, push_ok, drop, ctrl_wr;
  logic            empty, full;
  logic [KW-1:0]   head;
  logic [13:0]     code_f;
  logic            unused_dat;

  function automatic logic [4:0] sat5(input logic [NW-1:0] n);
    int v;
    v = int'(n);
    return (v > 31) ? 5'd31 : 5'(v);
  endfunction

  assign unused_dat = ^wb_dat_i[15:2];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rs1_q <= '1;
      rs_q  <= '1;
    end else begin
      rs1_q <= row;
      rs_q  <= rs1_q;
    end
  end

  assign any_low = ~&rs_q;

  always_comb begin
    low_idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rs_q[i]) low_idx = RW'(i);
    end
  end

  assign code = KW'(int'(c_q) * ROWS + int'(r_q));

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    div_d   = div_q;
    c_d     = c_q;
    r_d     = r_q;
    col     = '0;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_low) begin
          deb_d   = '0;
          state_d = S_DEB_PRESS;
        end
      end
      S_DEB_PRESS: begin
        if (!any_low) begin
          state_d = S_IDLE;
        end else if (deb_q == DW'(DEBOUNCE - 2)) begin
          state_d = S_SCAN;
          c_d     = '0;
          div_d   = '0;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      S_SCAN: begin
        col = ~(COLS'(1) << c_q);
        // Rows are sampled only on the last hold cycle so the synchronizer has caught up.
        if (div_q == SW'(SCAN_DIV - 1)) begin
          div_d = '0;
          if (any_low) begin
            r_d     = low_idx;
            state_d = S_PUSH;
          end else if (c_q == CW'(COLS - 1)) begin
            c_d     = '0;
            state_d = S_IDLE;
          end else begin
            c_d = c_q + CW'(1);
          end
        end else begin
          div_d = div_q + SW'(1);
        end
      end
      S_PUSH: begin
        col     = ~(COLS'(1) << c_q);
        push    = 1'b1;
        deb_d   = '0;
        state_d = S_DEB_REL;
      end
      S_DEB_REL: begin
        if (any_low) begin
          deb_d = '0;
        end else if (deb_q == DW'(DEBOUNCE - 1)) begin
          c_d     = '0;
          state_d = S_IDLE;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      deb_q   <= '0;
      div_q   <= '0;
      c_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      div_q   <= div_d;
      c_q     <= c_d;
      r_q     <= r_d;
    end
  end

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == NW'(FIFO_DEPTH));
  assign rd_acc  = !CS_N && !IOR_N;
  assign wr_acc  = !CS_N && !IOW_N;
  // One pop per access: only the first cycle of a DATA read strobe counts.
  assign pop     = rd_acc && !rd_act_q && !addr && !empty;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign ctrl_wr = wr_acc && !wr_act_q && addr;
  assign head    = mem_q[rp_q];

  always_comb begin
    wp_d  = push_ok ? wp_q + AW'(1) : wp_q;
    rp_d  = pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + NW'(1);
      2'b01:   cnt_d = cnt_q - NW'(1);
      default: cnt_d = cnt_q;
    endcase
    ovf_d = ovf_q;
    if (ctrl_wr && wb_dat_i[0]) ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;
    ie_d = ctrl_wr ? wb_dat_i[1] : ie_q;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      ie_q     <= 1'b0;
      rd_act_q <= 1'b0;
      wr_act_q <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      ie_q     <= ie_d;
      rd_act_q <= rd_acc;
      wr_act_q <= wr_acc;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem_q[wp_q] <= code;
  end

  always_comb begin
    code_f = '0;
    if (!empty) code_f[KW-1:0] = head;
    if (CS_N || IOR_N) wb_dat_o = '0;
    else if (!addr)    wb_dat_o = {~empty, ovf_q, code_f};
    else               wb_dat_o = {ovf_q, full, empty, ie_q, 7'b0, sat5(cnt_q)};
  end

  assign irq_o = ie_q & (~empty | ovf_q);

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed and randomized bench for keypad_scan_fifo with a queue-based reference
// model of the key FIFO, overflow flag and interrupt enable.
module tb_keypad_scan_fifo;
  localparam int ROWS = 4, COLS = 4, DEBOUNCE = 20, SCAN_DIV = 4, FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b1, ior_n = 1'b1, iow_n = 1'b1, addr = 1'b0;
  logic [15:0] dat_i = '0;
  logic [15:0] dat_o;
  logic [3:0]  row, col;
  logic        irq;

  logic key_dn = 1'b0;
  int   key_r = 0, key_c = 0;

  int total = 0, passed = 0, fails = 0;
  logic [3:0] mq[$];
  logic m_ovf = 1'b0, m_ie = 1'b0;

  keypad_scan_fifo #(
    .ROWS(ROWS), .COLS(COLS), .DEBOUNCE(DEBOUNCE), .SCAN_DIV(SCAN_DIV), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .CS_N(cs_n), .IOR_N(ior_n), .IOW_N(iow_n),
    .addr(addr), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .row(row), .col(col), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = '1;
    if (key_dn && col[key_c] == 1'b0) row[key_r] = 1'b0;
  end

  function automatic logic [15:0] m_data();
    if (mq.size() == 0) return {1'b0, m_ovf, 14'b0};
    return {1'b1, m_ovf, 10'b0, mq[0]};
  endfunction

  function automatic logic [15:0] m_status();
    return {m_ovf, mq.size() == FIFO_DEPTH, mq.size() == 0, m_ie, 7'b0, 5'(mq.size())};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press(input int r, input int c, input int hold);
    @(negedge clk);
    key_r = r; key_c = c; key_dn = 1'b1;
    repeat (hold) @(negedge clk);
    key_dn = 1'b0;
    repeat (45) @(negedge clk);
    if (mq.size() == FIFO_DEPTH) m_ovf = 1'b1;
    else mq.push_back(4'(c * ROWS + r));
  endtask

  task automatic rd(input logic a, input int len, output logic [15:0] v);
    @(negedge clk);
    cs_n = 1'b0; ior_n = 1'b0; addr = a;
    #1 v = dat_o;
    repeat (len) @(negedge clk);
    cs_n = 1'b1; ior_n = 1'b1; addr = 1'b0;
    if (!a && mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic rd_chk(input string tag, input logic a);
    logic [15:0] exp, v;
    exp = a ? m_status() : m_data();
    rd(a, 1, v);
    check(tag, v, exp);
  endtask

  task automatic wr(input logic [15:0] d);
    @(negedge clk);
    cs_n = 1'b0; iow_n = 1'b0; addr = 1'b1; dat_i = d;
    @(negedge clk);
    cs_n = 1'b1; iow_n = 1'b1; addr = 1'b0;
    if (d[0]) m_ovf = 1'b0;
    m_ie = d[1];
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int n;

    repeat (3) @(negedge clk);
    check("rst_col", {12'b0, col}, 16'h0000);
    check("rst_irq", {15'b0, irq}, 16'h0000);
    check("rst_dat_idle", dat_o, 16'h0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rd(1'b1, 1, v); check("rst_status", v, 16'h2000);

    // Reset mid-scan with a queued code and interrupt pending
    wr(16'h0002);
    press(1, 0, 60);
    check("pre_rst_irq", {15'b0, irq}, 16'h0001);
    key_r = 2; key_c = 3; key_dn = 1'b1;
    n = 0;
    while (col == 4'b0000 && n < 200) begin @(negedge clk); n++; end
    check("scan_reached", {15'b0, col != 4'b0000}, 16'h0001);
    rst = 1'b1;
    #1;
    check("midscan_col", {12'b0, col}, 16'h0000);
    check("midscan_irq", {15'b0, irq}, 16'h0000);
    key_dn = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_ie = 1'b0;
    repeat (3) @(negedge clk);
    rd(1'b1, 1, v); check("midscan_status", v, 16'h2000);

    // Single clean key
    press(2, 1, 100);
    rd(1'b0, 1, v); check("single_data", v, 16'h8006);
    rd(1'b0, 1, v); check("single_empty", v, 16'h0000);

    // Bouncing press and release on row 0 / column 3
    key_r = 0; key_c = 3; key_dn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      key_dn = ~key_dn;
      repeat (5) @(negedge clk);
    end
    key_dn = 1'b1;
    repeat (60) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      key_dn = ~key_dn;
      repeat (5) @(negedge clk);
    end
    key_dn = 1'b0;
    repeat (45) @(negedge clk);
    mq.push_back(4'd12);
    rd(1'b1, 1, v); check("bounce_status", v, 16'h0001);
    rd(1'b0, 1, v); check("bounce_data", v, 16'h800C);
    rd(1'b0, 1, v); check("bounce_empty", v, 16'h0000);

    // FIFO full and overflow
    press(0, 0, 60); press(1, 1, 60); press(2, 2, 60); press(3, 3, 60); press(1, 0, 60);
    rd(1'b1, 1, v); check("ovf_status", v, 16'hC004);
    check("ovf_irq_masked", {15'b0, irq}, 16'h0000);
    rd(1'b0, 1, v); check("ovf_rd0", v, 16'hC000);
    rd(1'b0, 1, v); check("ovf_rd1", v, 16'hC005);
    rd(1'b0, 1, v); check("ovf_rd2", v, 16'hC00A);
    rd(1'b0, 1, v); check("ovf_rd3", v, 16'hC00F);
    rd(1'b1, 1, v); check("ovf_drained", v, 16'hA000);
    wr(16'h0001);
    rd(1'b1, 1, v); check("ovf_cleared", v, 16'h2000);

    // Long read strobe pops once
    press(3, 0, 60); press(3, 1, 60);
    rd(1'b0, 10, v); check("long_data", v, 16'h8003);
    rd(1'b1, 1, v); check("long_status", v, 16'h0001);
    rd(1'b0, 1, v); check("long_next", v, 16'h8007);

    // Pop coinciding with PUSH while full
    press(2, 0, 60); press(0, 1, 60); press(2, 1, 60); press(0, 2, 60);
    rd(1'b1, 1, v); check("sim_full_status", v, 16'h4004);
    key_r = 3; key_c = 2; key_dn = 1'b1;
    n = 0;
    @(negedge clk);
    while (col != 4'b1011 && n < 200) begin @(negedge clk); n++; end
    check("sim_scan_col2", {12'b0, col}, 16'h000B);
    repeat (SCAN_DIV) @(negedge clk);
    cs_n = 1'b0; ior_n = 1'b0; addr = 1'b0;
    #1 v = dat_o;
    check("sim_head", v, 16'h8002);
    @(negedge clk);
    cs_n = 1'b1; ior_n = 1'b1;
    check("sim_deb_rel_col", {12'b0, col}, 16'h0000);
    void'(mq.pop_front());
    mq.push_back(4'd11);
    key_dn = 1'b0;
    repeat (45) @(negedge clk);
    rd(1'b1, 1, v); check("sim_status", v, 16'h4004);
    rd(1'b0, 1, v); check("sim_rd0", v, 16'h8004);
    rd(1'b0, 1, v); check("sim_rd1", v, 16'h8006);
    rd(1'b0, 1, v); check("sim_rd2", v, 16'h8008);
    rd(1'b0, 1, v); check("sim_rd3", v, 16'h800B);

    // Interrupt
    wr(16'h0002);
    check("irq_idle", {15'b0, irq}, 16'h0000);
    rd(1'b1, 1, v); check("irq_status", v, 16'h3000);
    press(1, 2, 60);
    check("irq_set", {15'b0, irq}, 16'h0001);
    rd(1'b0, 1, v); check("irq_data", v, 16'h8009);
    check("irq_clear", {15'b0, irq}, 16'h0000);

    // Randomized presses and reads against the model
    for (int i = 0; i < 10; i++) begin
      press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(50, 90)));
      if ($urandom_range(0, 1) == 1) rd_chk("rnd_data", 1'b0);
      check("rnd_irq", {15'b0, irq}, {15'b0, m_ie & ((mq.size() > 0) | m_ovf)});
      rd_chk("rnd_status", 1'b1);
    end
    n = 0;
    while (mq.size() > 0 && n < 8) begin rd_chk("rnd_drain", 1'b0); n++; end
    rd_chk("rnd_final_data", 1'b0);
    wr(16'h0001);
    rd_chk("rnd_final_status", 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
